rv32_core: RTL and testbench
============================

Name: rv32_core

Overview:
- Single-cycle RV32I integer core, with the M extension (multiply/divide) optionally enabled by parameters.
- Fetches one instruction per clock from the instruction port of a dual-port, word-organised memory and issues at most one data access per clock.
- Sits between the top level and the memory. The top level decodes special store addresses (halt at 0x2000_0000, signature bounds at 0x2000_0004/0x2000_0008) from this block's data-port outputs.

Parameters:
- XLEN, 32, datapath and register width; only 32 is supported.
- ENABLE_MUL, 0, 1 enables MUL/MULH/MULHSU/MULHU.
- ENABLE_DIV, 0, 1 enables DIV/DIVU/REM/REMU.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- inst  input  XLEN  instruction word at pc; combinational (async) memory read.
- load_data  input  XLEN  memory word at address[XLEN-1:2]; combinational read.
- mem_load  output  1  high while the current instruction is a LOAD.
- mem_store  output  1  high while the current instruction is a STORE; memory writes the whole word at the next posedge.
- store_data  output  XLEN  full word to write.
- address  output  XLEN  byte address of the data access (rs1 + imm).
- pc  output  XLEN  byte address of the current instruction.

Behaviour:
- Reset: at a posedge with reset=1, pc <= RESET_PC and all x1..x31 <= 0.
  - While reset is high, mem_load=0 and mem_store=0.
  - store_data and address are don't-care during reset.
- Execution: one instruction retires per clock.
  - Writeback to rd and the pc update both occur at the posedge ending the cycle.
  - The memory samples mem_store and store_data at the same edge.
- x0 always reads 0; writes to x0 are dropped.
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP.
  - FENCE, ECALL, EBREAK, SYSTEM/CSR and unknown opcodes execute as NOPs: pc+4, no writeback, no memory strobe.
- Next pc:
  - Taken branch or JAL: pc+imm.
  - JALR: (rs1+imm) with bit0 cleared.
  - Otherwise: pc+4.
  - JAL/JALR write pc+4 to rd.
  - No misalignment trap; arithmetic wraps modulo 2^32.
- Loads: select the byte with address[1:0], or the halfword with address[1], from load_data.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW uses the whole word and ignores address[1:0].
- Stores: the memory has no byte enables, so sub-word stores are read-modify-write within the same cycle.
  - store_data = load_data with the selected byte (SB) or halfword (SH) replaced by rs2's low bits.
  - SW drives rs2 unchanged.
- Shifts use the low 5 bits of the shift amount. SRA/SRAI are arithmetic. SLT/SLTU produce 0/1.
- M extension, combinational, same-cycle result:
  - MULH is signed×signed, MULHSU is signed×unsigned, MULHU is unsigned×unsigned; each returns the upper 32 bits of the 64-bit product.
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed overflow (0x8000_0000 / -1): DIV returns 0x8000_0000; REM returns 0.
  - A disabled feature's instructions execute as NOPs.
- Reset asserted mid-program overrides the current instruction: no writeback and no store that cycle.

Test Plan:
- Reset, then ADDI x1,x0,5; ADDI x2,x1,-7 -> pc 0,4,8; x1=5, x2=0xFFFF_FFFE; ADDI x0,x0,1 leaves x0=0.
- Word at 0x100 = 0x1122_3344; SB x3(=0xAB) to 0x101 -> stored word 0x1122_AB44. Then LB from 0x101 -> 0xFFFF_FFAB; LBU -> 0x0000_00AB; LH from 0x102 -> 0x0000_1122.
- BEQ with x1==x2, imm=-8 at pc 0x20 -> next pc 0x18. BLTU with 0xFFFF_FFFF vs 1 -> not taken. JALR rs1=0x41, imm=0 -> pc 0x40, rd=old pc+4.
- ENABLE_MUL=ENABLE_DIV=1:
  - MULH(-2,3) -> 0xFFFF_FFFF; MULHU(0xFFFF_FFFF,2) -> 1.
  - DIV(7,0) -> 0xFFFF_FFFF; REM(7,0) -> 7.
  - DIV(0x8000_0000,-1) -> 0x8000_0000; REM of the same -> 0.
- SW x5(=1) to 0x2000_0000 -> mem_store=1, address=0x2000_0000, store_data=1 in that cycle.
- Reset asserted during a SW -> mem_store=0; pc=RESET_PC after the edge; registers cleared.

Source files
------------

// File: rtl/rv32_core.sv
// rv32_core: single-cycle RV32I integer core with optional M-extension
// multiply/divide. One instruction is fetched and retired per clock; at most
// one data access is issued per cycle. Sub-word stores are read-modify-write
// because the attached memory has no byte enables.
module rv32_core #(
    parameter int          XLEN       = 32,
    parameter bit          ENABLE_MUL = 1'b0,
    parameter bit          ENABLE_DIV = 1'b0,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] load_data,
    output logic            mem_load,
    output logic            mem_store,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] address,
    output logic [XLEN-1:0] pc
);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_MISC   = 7'b0001111,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Architectural state
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] regs_q [32];

    // Instruction fields
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [6:0] opcode;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    // Immediates
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Register operands; entry 0 is held at zero so x0 needs no read mux.
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];

    logic [XLEN-1:0] pc_plus4;
    assign pc_plus4 = pc_q + 32'd4;

    // One adder serves the load/store address and the JALR target.
    assign address = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

    // ------------------------------------------------------------------
    // Integer ALU shared by OP and OP-IMM
    // ------------------------------------------------------------------
    logic [XLEN-1:0] alu_b;
    logic [4:0]      shamt;
    logic            is_op;
    logic            alu_valid;
    logic [XLEN-1:0] alu_result;

    assign is_op = (opcode == OPC_OP);
    assign alu_b = is_op ? rs2_val : imm_i;
    assign shamt = alu_b[4:0];

    // Base integer operation select plus encoding validity of funct7.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        alu_result = '0;
        alu_valid  = 1'b1;
        unique case (funct3)
            3'b000: alu_result = (is_op && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001: alu_result = rs1_val << shamt;
            3'b010: alu_result = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_result = {31'b0, rs1_val < alu_b};
            3'b100: alu_result = rs1_val ^ alu_b;
            3'b101: alu_result = funct7[5] ? $unsigned($signed(rs1_val) >>> shamt)
                                           : rs1_val >> shamt;
            3'b110: alu_result = rs1_val | alu_b;
            3'b111: alu_result = rs1_val & alu_b;
            default: alu_result = '0;
        endcase
        if (is_op) begin
            alu_valid = (funct7 == F7_BASE) ||
                        (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
        end else if (funct3 == 3'b001) begin
            alu_valid = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
            alu_valid = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end
    end

    // ------------------------------------------------------------------
    // M extension: same-cycle multiply and divide
    // ------------------------------------------------------------------
    logic                   mul_a_signed, mul_b_signed;
    logic [2*XLEN-1:0]      mul_a, mul_b, mul_prod;
    logic                   div_by_zero, div_overflow;
    logic [XLEN-1:0]        sdivisor, udivisor;
    logic signed [XLEN-1:0] sdiv_q, srem_q;
    logic [XLEN-1:0]        udiv_q, urem_q;
    logic                   m_valid;
    logic [XLEN-1:0]        m_result;

    // MULH is signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
    assign mul_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010);
    assign mul_b_signed = (funct3 == 3'b001);
    // Sign-extending to 64 bits makes a plain 64-bit product exact for all variants.
    assign mul_a    = {{XLEN{mul_a_signed & rs1_val[XLEN-1]}}, rs1_val};
    assign mul_b    = {{XLEN{mul_b_signed & rs2_val[XLEN-1]}}, rs2_val};
    assign mul_prod = mul_a * mul_b;

    assign div_by_zero  = (rs2_val == '0);
    assign div_overflow = (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
    // Dividing by 1 in the overflow case yields exactly the required 0x8000_0000 / 0.
    assign sdivisor = (div_by_zero || div_overflow) ? {{(XLEN-1){1'b0}}, 1'b1} : rs2_val;
    assign udivisor = div_by_zero ? {{(XLEN-1){1'b0}}, 1'b1} : rs2_val;
    assign sdiv_q   = $signed(rs1_val) / $signed(sdivisor);
    assign srem_q   = $signed(rs1_val) % $signed(sdivisor);
    assign udiv_q   = rs1_val / udivisor;
    assign urem_q   = rs1_val % udivisor;

    assign m_valid = (funct7 == F7_MULDIV) && (funct3[2] ? ENABLE_DIV : ENABLE_MUL);

    // M-extension result select, with the divide-by-zero results.
    always_comb begin
        m_result = '0;
        unique case (funct3)
            3'b000: m_result = mul_prod[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011: m_result = mul_prod[2*XLEN-1:XLEN];
            3'b100: m_result = div_by_zero ? '1 : $unsigned(sdiv_q);
            3'b101: m_result = div_by_zero ? '1 : udiv_q;
            3'b110: m_result = div_by_zero ? rs1_val : $unsigned(srem_q);
            3'b111: m_result = div_by_zero ? rs1_val : urem_q;
            default: m_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Branch compare
    // ------------------------------------------------------------------
    logic branch_valid, branch_taken;

    // Condition evaluation for the six branch types; funct3 010/011 are illegal.
    always_comb begin
        branch_valid = 1'b1;
        branch_taken = 1'b0;
        unique case (funct3)
            3'b000: branch_taken = (rs1_val == rs2_val);
            3'b001: branch_taken = (rs1_val != rs2_val);
            3'b100: branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101: branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: branch_taken = (rs1_val <  rs2_val);
            3'b111: branch_taken = (rs1_val >= rs2_val);
            default: branch_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Load extract and store merge
    // ------------------------------------------------------------------
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            load_valid, store_valid;
    logic [XLEN-1:0] load_result;

    assign ld_half = address[1] ? load_data[31:16] : load_data[15:0];

    // Byte/halfword selection and extension of the loaded word.
    always_comb begin
        unique case (address[1:0])
            2'd0:    ld_byte = load_data[7:0];
            2'd1:    ld_byte = load_data[15:8];
            2'd2:    ld_byte = load_data[23:16];
            default: ld_byte = load_data[31:24];
        endcase
        load_valid  = 1'b1;
        load_result = load_data;
        unique case (funct3)
            3'b000: load_result = {{24{ld_byte[7]}}, ld_byte};
            3'b001: load_result = {{16{ld_half[15]}}, ld_half};
            3'b010: load_result = load_data;
            3'b100: load_result = {24'b0, ld_byte};
            3'b101: load_result = {16'b0, ld_half};
            default: load_valid = 1'b0;
        endcase
    end

    // Store word: sub-word stores patch rs2 into the word currently in memory.
    always_comb begin
        store_valid = 1'b1;
        store_data  = rs2_val;
        unique case (funct3)
            3'b000: begin
                store_data = load_data;
                unique case (address[1:0])
                    2'd0:    store_data[7:0]   = rs2_val[7:0];
                    2'd1:    store_data[15:8]  = rs2_val[7:0];
                    2'd2:    store_data[23:16] = rs2_val[7:0];
                    default: store_data[31:24] = rs2_val[7:0];
                endcase
            end
            3'b001: begin
                store_data = load_data;
                if (address[1]) store_data[31:16] = rs2_val[15:0];
                else            store_data[15:0]  = rs2_val[15:0];
            end
            3'b010:  store_data = rs2_val;
            default: store_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Main decode: next pc, writeback and memory strobes
    // ------------------------------------------------------------------
    logic            wb_en, load_en, store_en;
    logic [XLEN-1:0] wb_data;

    // Per-opcode control; anything not listed retires as a NOP.
    always_comb begin
        pc_d     = pc_plus4;
        wb_en    = 1'b0;
        wb_data  = alu_result;
        load_en  = 1'b0;
        store_en = 1'b0;
        case (opcode)
            OPC_LUI: begin
                wb_en   = 1'b1;
                wb_data = imm_u;
            end
            OPC_AUIPC: begin
                wb_en   = 1'b1;
                wb_data = pc_q + imm_u;
            end
            OPC_JAL: begin
                pc_d    = pc_q + imm_j;
                wb_en   = 1'b1;
                wb_data = pc_plus4;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    pc_d    = {address[XLEN-1:1], 1'b0};
                    wb_en   = 1'b1;
                    wb_data = pc_plus4;
                end
            end
            OPC_BRANCH: begin
                if (branch_valid && branch_taken) pc_d = pc_q + imm_b;
            end
            OPC_LOAD: begin
                load_en = load_valid;
                wb_en   = load_valid;
                wb_data = load_result;
            end
            OPC_STORE: store_en = store_valid;
            OPC_OP_IMM: wb_en = alu_valid;
            OPC_OP: begin
                if (m_valid) begin
                    wb_en   = 1'b1;
                    wb_data = m_result;
                end else begin
                    wb_en = alu_valid;
                end
            end
            default: ;
        endcase
    end

    // Reset suppresses both strobes so a store in flight never reaches memory.
    assign mem_load  = load_en & ~reset;
    assign mem_store = store_en & ~reset;
    assign pc        = pc_q;

    // State update: pc and register file, both cleared by synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            pc_q <= RESET_PC;
            // NOTE: the register file is reset here because the architecture requires x1..x31 = 0 after reset.
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (wb_en && rd != 5'd0) regs_q[rd] <= wb_data;
        end
    end

endmodule

// File: tb/tb_rv32_core.sv
// tb_rv32_core: table-driven bench for rv32_core. Each table row supplies one
// instruction with its expected pc and strobes; expected stores go to a
// scoreboard queue and are matched when the core raises mem_store.
module tb_rv32_core;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int OPI = 'h13, OPR = 'h33, LDO = 'h03, LUIO = 'h37, AUIO = 'h17, JALRO = 'h67;

    typedef enum {K_NONE, K_LOAD, K_STORE} kind_e;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] pc;
        kind_e       kind;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        string       name;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic [31:0] load_data;
    logic        mem_load, mem_store;
    logic [31:0] store_data, address, pc;

    logic [31:0] dmem [0:255];
    vec_t        vecs [$];
    exp_t        sb   [$];
    int          total = 0;
    int          bad   = 0;

    rv32_core #(
        .XLEN       (32),
        .ENABLE_MUL (1'b1),
        .ENABLE_DIV (1'b1),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .inst       (inst),
        .load_data  (load_data),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .store_data (store_data),
        .address    (address),
        .pc         (pc)
    );

    always #5 clock = ~clock;

    // Word-organised data memory without byte enables.
    assign load_data = dmem[address[9:2]];
    always @(posedge clock) begin
        if (!reset && mem_store) dmem[address[9:2]] <= store_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] i, s, f, d, o;
        i = imm; s = rs1; f = f3; d = rd; o = op;
        return {i[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] g, t, s, f, d;
        g = f7; t = rs2; s = rs1; f = f3; d = rd;
        return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] i, t, s, f;
        i = imm; t = rs2; s = rs1; f = f3;
        return {i[11:5], t[4:0], s[4:0], f[2:0], i[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs1, input int rs2, input int f3);
        logic [31:0] i, t, s, f;
        i = imm; t = rs2; s = rs1; f = f3;
        return {i[12], i[10:5], t[4:0], s[4:0], f[2:0], i[4:1], i[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
        logic [31:0] i, d, o;
        i = imm20; d = rd; o = op;
        return {i[19:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] i, d;
        i = imm; d = rd;
        return {i[20], i[10:1], i[11], i[19:12], d[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, OPI);
    endfunction

    function automatic logic [31:0] sw(input int rs2, input int imm, input int rs1);
        return enc_s(imm, rs2, rs1, 2);
    endfunction

    task automatic add(input string n, input logic [31:0] i, input logic [31:0] p,
                       input kind_e k, input logic [31:0] a, input logic [31:0] d);
        vec_t v;
        v.name = n; v.inst = i; v.pc = p; v.kind = k; v.addr = a; v.data = d;
        vecs.push_back(v);
    endtask

    // Scoreboard: every store the core issues must match the oldest expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (mem_store === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_store: got addr 0x%08h data 0x%08h, want no store", address, store_data);
            end else begin
                e = sb.pop_front();
                check({e.name, "_addr"}, address, e.addr);
                check({e.name, "_data"}, store_data, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
        dmem[8'h40] <= 32'h1122_3344;

        // ---------------- program table ----------------
        add("addi_x1",   addi(1, 0, 5),              0,   K_NONE,  0, 0);
        add("addi_x2",   addi(2, 1, -7),             4,   K_NONE,  0, 0);
        add("addi_x0",   addi(0, 0, 1),              8,   K_NONE,  0, 0);
        add("sw_x1",     sw(1, 'h10, 0),             12,  K_STORE, 'h10, 5);
        add("sw_x2",     sw(2, 'h14, 0),             16,  K_STORE, 'h14, 32'hFFFF_FFFE);
        add("sw_x0",     sw(0, 'h18, 0),             20,  K_STORE, 'h18, 0);
        add("addi_x3",   addi(3, 0, 'hAB),           24,  K_NONE,  0, 0);
        add("addi_x4",   addi(4, 0, 'h100),          28,  K_NONE,  0, 0);
        add("sb_101",    enc_s(1, 3, 4, 0),          32,  K_STORE, 'h101, 32'h1122_AB44);
        add("lb_101",    enc_i(1, 4, 0, 5, LDO),     36,  K_LOAD,  'h101, 0);
        add("lbu_101",   enc_i(1, 4, 4, 6, LDO),     40,  K_LOAD,  'h101, 0);
        add("lh_102",    enc_i(2, 4, 1, 7, LDO),     44,  K_LOAD,  'h102, 0);
        add("lw_103",    enc_i(3, 4, 2, 8, LDO),     48,  K_LOAD,  'h103, 0);
        add("res_lb",    sw(5, 'h20, 0),             52,  K_STORE, 'h20, 32'hFFFF_FFAB);
        add("res_lbu",   sw(6, 'h24, 0),             56,  K_STORE, 'h24, 32'h0000_00AB);
        add("res_lh",    sw(7, 'h28, 0),             60,  K_STORE, 'h28, 32'h0000_1122);
        add("res_lw",    sw(8, 'h2C, 0),             64,  K_STORE, 'h2C, 32'h1122_AB44);
        add("sh_102",    enc_s(2, 3, 4, 1),          68,  K_STORE, 'h102, 32'h00AB_AB44);
        add("addi_x9",   addi(9, 0, -1),             72,  K_NONE,  0, 0);
        add("addi_x10",  addi(10, 0, 1),             76,  K_NONE,  0, 0);
        add("bltu_nt",   enc_b(16, 9, 10, 6),        80,  K_NONE,  0, 0);
        add("blt_t",     enc_b(12, 9, 10, 4),        84,  K_NONE,  0, 0);
        add("beq_back",  enc_b(-8, 10, 10, 0),       96,  K_NONE,  0, 0);
        add("bne_nt",    enc_b(100, 10, 10, 1),      88,  K_NONE,  0, 0);
        add("jal",       enc_j(20, 11),              92,  K_NONE,  0, 0);
        add("addi_x12",  addi(12, 0, 'h41),          112, K_NONE,  0, 0);
        add("jalr",      enc_i(0, 12, 0, 13, JALRO), 116, K_NONE,  0, 0);
        add("res_jal",   sw(11, 'h30, 0),            64,  K_STORE, 'h30, 32'h60);
        add("res_jalr",  sw(13, 'h34, 0),            68,  K_STORE, 'h34, 32'h78);
        add("lui_x14",   enc_u('h80000, 14, LUIO),   72,  K_NONE,  0, 0);
        add("addi_x15",  addi(15, 0, -2),            76,  K_NONE,  0, 0);
        add("addi_x16",  addi(16, 0, 3),             80,  K_NONE,  0, 0);
        add("addi_x17",  addi(17, 0, 2),             84,  K_NONE,  0, 0);
        add("addi_x21",  addi(21, 0, 7),             88,  K_NONE,  0, 0);
        add("mulh",      enc_r(1, 16, 15, 1, 18),    92,  K_NONE,  0, 0);
        add("mulhu",     enc_r(1, 17, 9, 3, 19),     96,  K_NONE,  0, 0);
        add("div0",      enc_r(1, 0, 21, 4, 20),     100, K_NONE,  0, 0);
        add("rem0",      enc_r(1, 0, 21, 6, 22),     104, K_NONE,  0, 0);
        add("div_ovf",   enc_r(1, 9, 14, 4, 23),     108, K_NONE,  0, 0);
        add("rem_ovf",   enc_r(1, 9, 14, 6, 24),     112, K_NONE,  0, 0);
        add("res_mulh",  sw(18, 'h40, 0),            116, K_STORE, 'h40, 32'hFFFF_FFFF);
        add("res_mulhu", sw(19, 'h44, 0),            120, K_STORE, 'h44, 32'h1);
        add("res_div0",  sw(20, 'h48, 0),            124, K_STORE, 'h48, 32'hFFFF_FFFF);
        add("res_rem0",  sw(22, 'h4C, 0),            128, K_STORE, 'h4C, 32'h7);
        add("res_dovf",  sw(23, 'h50, 0),            132, K_STORE, 'h50, 32'h8000_0000);
        add("res_rovf",  sw(24, 'h54, 0),            136, K_STORE, 'h54, 32'h0);
        add("srai",      enc_i('h404, 14, 5, 25, OPI), 140, K_NONE, 0, 0);
        add("slt",       enc_r(0, 10, 9, 2, 26),     144, K_NONE,  0, 0);
        add("sltu",      enc_r(0, 10, 9, 3, 27),     148, K_NONE,  0, 0);
        add("mul",       enc_r(1, 16, 15, 0, 28),    152, K_NONE,  0, 0);
        add("ecall",     32'h0000_0073,              156, K_NONE,  0, 0);
        add("auipc",     enc_u(1, 29, AUIO),         160, K_NONE,  0, 0);
        add("res_srai",  sw(25, 'h58, 0),            164, K_STORE, 'h58, 32'hF800_0000);
        add("res_slt",   sw(26, 'h5C, 0),            168, K_STORE, 'h5C, 32'h1);
        add("res_sltu",  sw(27, 'h60, 0),            172, K_STORE, 'h60, 32'h0);
        add("res_mul",   sw(28, 'h64, 0),            176, K_STORE, 'h64, 32'hFFFF_FFFA);
        add("res_auipc", sw(29, 'h68, 0),            180, K_STORE, 'h68, 32'h0000_10A0);
        add("addi_x5",   addi(5, 0, 1),              184, K_NONE,  0, 0);
        add("lui_x30",   enc_u('h20000, 30, LUIO),   188, K_NONE,  0, 0);
        add("sw_halt",   sw(5, 0, 30),               192, K_STORE, 32'h2000_0000, 32'h1);

        // ---------------- reset: strobes held low ----------------
        reset = 1'b1;
        inst  = sw(5, 0, 30);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_store", 32'(mem_store), 32'h0);
        inst = enc_i(0, 0, 2, 1, LDO);
        #1;
        check("rst_load", 32'(mem_load), 32'h0);
        @(posedge clock);
        #1;
        check("rst_pc", pc, RESET_PC);
        reset = 1'b0;

        // ---------------- table-driven program ----------------
        foreach (vecs[k]) begin
            inst = vecs[k].inst;
            if (vecs[k].kind == K_STORE)
                sb.push_back('{addr: vecs[k].addr, data: vecs[k].data, name: vecs[k].name});
            @(negedge clock);
            check({vecs[k].name, "_pc"}, pc, vecs[k].pc);
            check({vecs[k].name, "_ld"}, 32'(mem_load), 32'(vecs[k].kind == K_LOAD));
            check({vecs[k].name, "_st"}, 32'(mem_store), 32'(vecs[k].kind == K_STORE));
            if (vecs[k].kind == K_LOAD) check({vecs[k].name, "_addr"}, address, vecs[k].addr);
            @(posedge clock);
            #1;
        end

        // ---------------- reset asserted during a store ----------------
        inst  = sw(5, 0, 30);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_pc_before", pc, 32'd196);
        check("midrst_store", 32'(mem_store), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midrst_pc", pc, RESET_PC);

        // Registers must now read zero: x30 and x5 were nonzero before reset.
        sb.push_back('{addr: 32'h0, data: 32'h0, name: "midrst_x5_x30"});
        @(negedge clock);
        check("midrst_sw_pc", pc, RESET_PC);
        check("midrst_sw_st", 32'(mem_store), 32'h1);
        @(posedge clock);
        #1;
        inst = sw(1, 4, 0);
        sb.push_back('{addr: 32'h4, data: 32'h0, name: "midrst_x1"});
        @(negedge clock);
        check("midrst_x1_pc", pc, 32'd4);
        @(posedge clock);
        #1;
        inst = addi(0, 0, 0);
        @(negedge clock);
        check("sb_drain", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
